// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: hazard/redirect inputs, imem port, IF/ID outputs.
// slave = fetch stage, master = decode/hazard/imem side.
interface fetch_pc_unit_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        halted;

  modport slave (
    input  stall, flush,
    input  branch_taken, branch_offset,
    input  jump, jump_index,
    input  jr, jr_target,
    input  instr_in,
    output pc_out,
    output if_instr, if_pc4, if_valid,
    output halted
  );

  modport master (
    output stall, flush,
    output branch_taken, branch_offset,
    output jump, jump_index,
    output jr, jr_target,
    output instr_in,
    input  pc_out,
    input  if_instr, if_pc4, if_valid,
    input  halted
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// MIPS fetch stage: PC, next-PC select, IF/ID register.
// HALT_AT_MEM_END_EN: halt on next PC past memory end instead of wrapping.
module fetch_pc_unit #(
  parameter int unsigned MEM_SIZE = 128,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst_n,
  fetch_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam logic [32:0] MEM_BYTES =
    33'(MEM_SIZE) * 33'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;

  logic [31:0] pc_seq;
  logic [31:0] next_pc;
  logic        redirect;
  logic        past_end;

  always_comb begin
    pc_seq   = pc_q + 32'd4;
    redirect = bus.jr | bus.jump
             | bus.branch_taken;
    if (bus.jr)
      next_pc = bus.jr_target & ~32'd3;
    else if (bus.jump)
      next_pc = {ifid_q.pc4[31:28],
                 bus.jump_index, 2'b00};
    else if (bus.branch_taken)
      next_pc = ifid_q.pc4
              + (bus.branch_offset << 2);
    else
      next_pc = pc_seq;
    past_end = {1'b0, next_pc} >= MEM_BYTES;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    unique case (state_q)
      S_RESET: state_d = S_RUN;
      S_RUN: begin
        if (bus.stall) begin
          if (bus.flush) ifid_d.valid = 1'b0;
        end else begin
          ifid_d.instr = bus.instr_in;
          ifid_d.pc4   = pc_seq;
          ifid_d.valid = ~(bus.flush | redirect);
`ifdef HALT_AT_MEM_END_EN
          // last in-range PC stays on the bus
          if (past_end) state_d = S_HALT;
          else          pc_d    = next_pc;
`else
          if (past_end)
            pc_d = 32'({1'b0, next_pc} % MEM_BYTES);
          else
            pc_d = next_pc;
`endif
        end
      end
      S_HALT:  ifid_d.valid = 1'b0;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  assign bus.pc_out   = pc_q;
  assign bus.if_instr = ifid_q.instr;
  assign bus.if_pc4   = ifid_q.pc4;
  assign bus.if_valid = ifid_q.valid;
`ifdef HALT_AT_MEM_END_EN
  assign bus.halted   = (state_q == S_HALT);
`else
  assign bus.halted   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus
// randomized redirects checked against a fetch model.
module tb_fetch_pc_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic srst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit_if bi ();
  fetch_pc_unit_if si ();

  fetch_pc_unit #(.MEM_SIZE(128)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bi.slave)
  );

  fetch_pc_unit #(.MEM_SIZE(4)) dut_s (
    .clk  (clk),
    .rst_n(srst_n),
    .bus  (si.slave)
  );

  logic [31:0] mem [128];
  assign bi.instr_in = mem[bi.pc_out[8:2]];
  assign si.instr_in = {30'd0, si.pc_out[3:2]};

  // model of the 128-word instance
  localparam int M_RST  = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int MB     = 512;
  int          m_st;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  task automatic model_step();
    logic [31:0] tgt;
    if (!rst_n) begin
      m_st = M_RST; m_pc = 0;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (m_st == M_RST) begin
      m_st = M_RUN;
    end else if (m_st == M_HALT) begin
      m_valid = 0;
    end else if (bi.stall) begin
      if (bi.flush) m_valid = 0;
    end else begin
      if (bi.jr)
        tgt = {bi.jr_target[31:2], 2'b00};
      else if (bi.jump)
        tgt = {m_pc4[31:28], bi.jump_index, 2'b00};
      else if (bi.branch_taken)
        tgt = m_pc4 + bi.branch_offset * 4;
      else
        tgt = m_pc + 4;
      m_instr = mem[(m_pc / 4) % 128];
      m_pc4   = m_pc + 4;
      m_valid = !(bi.flush || bi.jr || bi.jump
                  || bi.branch_taken);
`ifdef HALT_AT_MEM_END_EN
      if (tgt >= MB) m_st = M_HALT;
      else           m_pc = tgt;
`else
      m_pc = tgt % MB;
`endif
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bi.stall = 0; bi.flush = 0;
    bi.branch_taken = 0; bi.branch_offset = 0;
    bi.jump = 0; bi.jump_index = 0;
    bi.jr = 0; bi.jr_target = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    checks++;
    if (bi.pc_out !== 32'd0 || bi.if_valid !== 1'b0
        || bi.if_instr !== 32'd0 || bi.if_pc4 !== 32'd0
        || bi.halted !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h v=%b i=%h p4=%h h=%b",
               bi.pc_out, bi.if_valid, bi.if_instr,
               bi.if_pc4, bi.halted);
    end
    rst_n = 1;
    tick();
    checks++;
    if (bi.pc_out !== 32'd0 || bi.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: pc=%h v=%b want 0 0",
               bi.pc_out, bi.if_valid);
    end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bi.pc_out !== 32'(4 * (k + 1))
          || bi.if_instr !== 32'(k)
          || bi.if_pc4 !== 32'(4 * (k + 1))
          || bi.if_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq%0d: pc=%h i=%h p4=%h v=%b",
                 k, bi.pc_out, bi.if_instr,
                 bi.if_pc4, bi.if_valid);
      end
    end
  endtask

  task automatic test_branch();
    tick();
    bi.branch_taken = 1;
    bi.branch_offset = -32'sd2;
    tick();
    idle_in();
    checks++;
    if (bi.pc_out !== 32'h8 || bi.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch: pc=%h v=%b want 8 0",
               bi.pc_out, bi.if_valid);
    end
    tick();
    checks++;
    if (bi.if_instr !== 32'd2 || bi.if_valid !== 1'b1) begin
      errors++;
      $display("FAIL branch_tgt: i=%h v=%b want 2 1",
               bi.if_instr, bi.if_valid);
    end
  endtask

  task automatic test_priority();
    bi.jump = 1; bi.jump_index = 26'h20;
    bi.jr = 1; bi.jr_target = 32'h40;
    bi.branch_taken = 1; bi.branch_offset = 32'd5;
    tick();
    idle_in();
    checks++;
    if (bi.pc_out !== 32'h40 || bi.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL priority: pc=%h v=%b want 40 0",
               bi.pc_out, bi.if_valid);
    end
    tick();
    checks++;
    if (bi.if_instr !== 32'd16 || bi.pc_out !== 32'h44) begin
      errors++;
      $display("FAIL prio_tgt: i=%h pc=%h want 10 44",
               bi.if_instr, bi.pc_out);
    end
  endtask

  task automatic test_stall();
    bi.stall = 1; bi.branch_taken = 1;
    bi.branch_offset = 32'd3;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bi.pc_out !== 32'h44 || bi.if_instr !== 32'd16
          || bi.if_pc4 !== 32'h44
          || bi.if_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d: pc=%h i=%h p4=%h v=%b",
                 k, bi.pc_out, bi.if_instr,
                 bi.if_pc4, bi.if_valid);
      end
    end
    bi.branch_taken = 0; bi.flush = 1;
    tick();
    checks++;
    if (bi.pc_out !== 32'h44 || bi.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush: pc=%h v=%b want 44 0",
               bi.pc_out, bi.if_valid);
    end
    idle_in();
    tick();
    checks++;
    if (bi.if_instr !== 32'd17 || bi.pc_out !== 32'h48
        || bi.if_valid !== 1'b1) begin
      errors++;
      $display("FAIL unstall: i=%h pc=%h v=%b",
               bi.if_instr, bi.pc_out, bi.if_valid);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bi.stall = ($urandom_range(0, 3) == 0);
      bi.flush = ($urandom_range(0, 5) == 0);
      bi.jr = ($urandom_range(0, 11) == 0);
      bi.jump = ($urandom_range(0, 7) == 0);
      bi.branch_taken = ($urandom_range(0, 5) == 0);
      bi.jr_target = $urandom_range(0, 511);
      bi.jump_index = 26'($urandom_range(0, 127));
      bi.branch_offset =
        32'(int'($urandom_range(0, 127))
            - int'(m_pc4 / 4));
      tick();
      checks++;
      if (bi.pc_out !== m_pc || bi.if_instr !== m_instr
          || bi.if_pc4 !== m_pc4 || bi.if_valid !== m_valid
          || bi.halted !== (m_st == M_HALT)) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand%0d: pc=%h/%h i=%h/%h p4=%h/%h v=%b/%b h=%b",
                   i, bi.pc_out, m_pc, bi.if_instr, m_instr,
                   bi.if_pc4, m_pc4, bi.if_valid, m_valid,
                   bi.halted);
      end
    end
    rst_n = 1;
    idle_in();
  endtask

  task automatic test_mem_end();
    srst_n = 0;
    tick();
    srst_n = 1;
    tick();
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (si.pc_out !== 32'd12 || si.if_instr !== 32'd2) begin
      errors++;
      $display("FAIL end_pre: pc=%h i=%h want c 2",
               si.pc_out, si.if_instr);
    end
    tick();
`ifdef HALT_AT_MEM_END_EN
    checks++;
    if (si.pc_out !== 32'd12 || si.halted !== 1'b1
        || si.if_instr !== 32'd3
        || si.if_valid !== 1'b1) begin
      errors++;
      $display("FAIL end_halt: pc=%h h=%b i=%h v=%b",
               si.pc_out, si.halted, si.if_instr,
               si.if_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (si.pc_out !== 32'd12 || si.halted !== 1'b1
          || si.if_valid !== 1'b0) begin
        errors++;
        $display("FAIL halted%0d: pc=%h h=%b v=%b",
                 k, si.pc_out, si.halted, si.if_valid);
      end
    end
`else
    checks++;
    if (si.pc_out !== 32'd0 || si.halted !== 1'b0
        || si.if_instr !== 32'd3
        || si.if_valid !== 1'b1) begin
      errors++;
      $display("FAIL end_wrap: pc=%h h=%b i=%h v=%b",
               si.pc_out, si.halted, si.if_instr,
               si.if_valid);
    end
    tick();
    checks++;
    if (si.pc_out !== 32'd4 || si.if_instr !== 32'd0
        || si.halted !== 1'b0) begin
      errors++;
      $display("FAIL wrap_next: pc=%h i=%h h=%b",
               si.pc_out, si.if_instr, si.halted);
    end
`endif
  endtask

  task automatic test_halt_reset();
    srst_n = 0;
    tick();
    checks++;
    if (si.halted !== 1'b0 || si.pc_out !== 32'd0
        || si.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_rst: h=%b pc=%h v=%b",
               si.halted, si.pc_out, si.if_valid);
    end
    srst_n = 1;
  endtask

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = 32'(k);
    rst_n = 0;
    srst_n = 0;
    idle_in();
    si.stall = 0; si.flush = 0;
    si.branch_taken = 0; si.branch_offset = 0;
    si.jump = 0; si.jump_index = 0;
    si.jr = 0; si.jr_target = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_stall();
    test_random();
    test_mem_end();
    test_halt_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
